// File: rtl/fft_corr_pkg.sv
// rtl/fft_corr_pkg.sv - shared stream-select encoding and widths for the FFT/correlation datapath
package fft_corr_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  // The same encoding drives both the demux and the mux select inputs.
  typedef enum logic [1:0] {
    SEL_IN1 = 2'b00,
    SEL_IN2 = 2'b01,
    SEL_IN3 = 2'b10,
    SEL_OFF = 2'b11
  } axis_sel_t;

  function automatic logic [2:0] sel_onehot(input axis_sel_t sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_IN1: oh = 3'b001;
      SEL_IN2: oh = 3'b010;
      SEL_IN3: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/axis_intf.sv
// rtl/axis_intf.sv - minimal AXI-Stream bundle (tdata/tvalid/tready) with master and slave views
interface AXIS_intf #(
  parameter int DATA_WIDTH = fft_corr_pkg::AXIS_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport Master (output tdata, output tvalid, input tready);
  modport Slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry register slice; tready, tvalid and tdata all come from flops
module axis_skid_buffer
  import fft_corr_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic     aclk,
  input  logic     areset,
  AXIS_intf.Slave  in_i,
  AXIS_intf.Master out_o
);

  logic [1:0]            occ_q, occ_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_hs;
  logic                  out_hs;

  assign in_hs  = in_i.tvalid & ready_q;
  assign out_hs = valid_q & out_o.tready;

  assign in_i.tready  = ready_q;
  assign out_o.tvalid = valid_q;
  assign out_o.tdata  = head_q;

  // head_q is the presented beat; skid_q only holds a beat that arrived while head stalled.
  always_comb begin
    occ_d   = occ_q;
    valid_d = valid_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (occ_q)
      2'd0: begin
        if (in_hs) begin
          head_d  = in_i.tdata;
          valid_d = 1'b1;
          occ_d   = 2'd1;
        end
      end
      2'd1: begin
        if (in_hs && out_hs) begin
          head_d = in_i.tdata;
        end else if (in_hs) begin
          skid_d = in_i.tdata;
          occ_d  = 2'd2;
        end else if (out_hs) begin
          valid_d = 1'b0;
          occ_d   = 2'd0;
        end
      end
      default: begin
        if (out_hs) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end
      end
    endcase
    ready_d = (occ_d != 2'd2);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      occ_q   <= 2'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/axis_frame_mux.sv
// rtl/axis_frame_mux.sv - 3-to-1 AXI-Stream mux switching only on FRAME_LEN-beat boundaries
// Optional sticky Sel_Err output when AXIS_FRAME_MUX_SEL_ERR_EN is defined.
module axis_frame_mux
  import fft_corr_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int FRAME_LEN  = 1024
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] Mux_Sel,
`ifdef AXIS_FRAME_MUX_SEL_ERR_EN
  output logic       Sel_Err,
`endif
  AXIS_intf.Slave    indata_1,
  AXIS_intf.Slave    indata_2,
  AXIS_intf.Slave    indata_3,
  AXIS_intf.Master   outdata
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  axis_sel_t        sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_oh;
  logic             buf_ready;
  logic             in_hs;
  logic             at_last;

  AXIS_intf #(.DATA_WIDTH(DATA_WIDTH)) mux_s ();

  assign sel_oh    = sel_onehot(sel_q);
  assign buf_ready = mux_s.tready;
  assign in_hs     = mux_s.tvalid & buf_ready;
  assign at_last   = (cnt_q == LAST_BEAT);

  assign indata_1.tready = sel_oh[0] & buf_ready;
  assign indata_2.tready = sel_oh[1] & buf_ready;
  assign indata_3.tready = sel_oh[2] & buf_ready;

  always_comb begin
    mux_s.tvalid = 1'b0;
    mux_s.tdata  = '0;
    case (sel_q)
      SEL_IN1: begin
        mux_s.tvalid = indata_1.tvalid;
        mux_s.tdata  = indata_1.tdata;
      end
      SEL_IN2: begin
        mux_s.tvalid = indata_2.tvalid;
        mux_s.tdata  = indata_2.tdata;
      end
      SEL_IN3: begin
        mux_s.tvalid = indata_3.tvalid;
        mux_s.tdata  = indata_3.tdata;
      end
      default: begin
        mux_s.tvalid = 1'b0;
        mux_s.tdata  = '0;
      end
    endcase
  end

  // Select may only move while idle at a boundary or on the beat that closes a frame.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (in_hs) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
    if ((cnt_q == '0 && !in_hs) || (in_hs && at_last)) begin
      sel_d = axis_sel_t'(Mux_Sel);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sel_q <= SEL_IN1;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef AXIS_FRAME_MUX_SEL_ERR_EN
  logic sel_err_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sel_err_q <= 1'b0;
    end else if ((axis_sel_t'(Mux_Sel) != sel_q) && (cnt_q != '0)) begin
      sel_err_q <= 1'b1;
    end
  end

  assign Sel_Err = sel_err_q;
`endif

  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .aclk   (aclk),
    .areset (areset),
    .in_i   (mux_s),
    .out_o  (outdata)
  );

endmodule
